mem_access_unit: RTL and testbench

- Initiator side of the data-memory port (port B) for the RISC-V core's load/store path; sits between the execute/memory stage and the unified memory.
- Accepts one load/store request at a time and issues word-granular memOp/addrB/dinB transactions.
- Waits for bValid, then returns byte/half/word load data with sign or zero extension.
- Sub-word stores are done as read-modify-write, because memory writes whole words only.

---
 rtl/mem_access_unit.sv | 175 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Data-memory port B initiator for the load/store path.
// One request at a time; sub-word stores are a read-modify-write of the whole word.
//
// state    | meaning
// IDLE     | ready for a request while mem_ready is high
// RD_ISSUE | read op on memOp for one cycle
// RD_WAIT  | wait for bValid, with timeout
// WR_ISSUE | write op on memOp for one cycle
// RESP     | drive the response registers, pulse rsp_valid on the next cycle
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  memOp,
    output logic [31:0] addrB,
    output logic [31:0] dinB,
    input  logic [31:0] doutB,
    input  logic        bValid,
    input  logic        mem_ready
);

    localparam logic [1:0] MEM_DISABLE   = 2'b00;
    localparam logic [1:0] MEM_READ_SEXT = 2'b01;
    localparam logic [1:0] MEM_READ_ZEXT = 2'b10;
    localparam logic [1:0] MEM_WRITE     = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_ISSUE, S_RD_WAIT, S_WR_ISSUE, S_RESP
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  cnt_inc;
    logic        store_q, unsigned_q, err_q;
    logic [1:0]  size_q, lane_q;
    logic [15:0] wdata_q;
    logic [31:0] rd_word_q;
    logic [1:0]  mem_op_q, mem_op_d;
    logic [31:0] addr_b_q, din_b_q;
    logic        rsp_valid_q, rsp_err_q;
    logic [31:0] rsp_rdata_q;

    logic        accept, misaligned, timeout;
    logic [31:0] load_data, merged;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    assign accept     = req_valid && req_ready;
    assign misaligned = (req_size == 2'b11) ||
                        (req_size == 2'b01 && req_addr[0]) ||
                        (req_size == 2'b10 && req_addr[1:0] != 2'b00);
    assign cnt_inc    = cnt_q + 8'd1;
    assign timeout    = (state_q == S_RD_WAIT) && !bValid && (cnt_inc == 8'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (misaligned)                          state_d = S_RESP;
                    else if (req_store && req_size == 2'b10) state_d = S_WR_ISSUE;
                    else                                     state_d = S_RD_ISSUE;
                end
            end
            S_RD_ISSUE: state_d = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bValid)       state_d = store_q ? S_WR_ISSUE : S_RESP;
                else begin
                    cnt_d = cnt_inc;
                    if (timeout) state_d = S_RESP;
                end
            end
            S_WR_ISSUE: state_d = S_RESP;
            S_RESP:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
        if (state_d == S_RD_ISSUE) cnt_d = 8'd0;
    end

    always_comb begin
        req_ready = (state_q == S_IDLE) && mem_ready;
        mem_op_d  = MEM_DISABLE;
        // RD_ISSUE is only entered from IDLE, so the live request fields apply
        if (state_d == S_RD_ISSUE)
            mem_op_d = (req_store || req_unsigned) ? MEM_READ_ZEXT : MEM_READ_SEXT;
        else if (state_d == S_WR_ISSUE)
            mem_op_d = MEM_WRITE;
    end

    always_comb begin
        ld_byte = rd_word_q[8*lane_q +: 8];
        ld_half = lane_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
        case (size_q)
            2'b00:   load_data = {{24{~unsigned_q & ld_byte[7]}}, ld_byte};
            2'b01:   load_data = {{16{~unsigned_q & ld_half[15]}}, ld_half};
            default: load_data = rd_word_q;
        endcase
        merged = doutB;
        if (size_q == 2'b00)    merged[8*lane_q +: 8] = wdata_q[7:0];
        else if (lane_q[1])     merged[31:16] = wdata_q;
        else                    merged[15:0]  = wdata_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            store_q     <= 1'b0;
            unsigned_q  <= 1'b0;
            err_q       <= 1'b0;
            size_q      <= 2'b00;
            lane_q      <= 2'b00;
            wdata_q     <= 16'd0;
            rd_word_q   <= 32'd0;
            mem_op_q    <= MEM_DISABLE;
            addr_b_q    <= 32'd0;
            din_b_q     <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= 32'd0;
        end else begin
            mem_op_q    <= mem_op_d;
            rsp_valid_q <= (state_q == S_RESP);
            if (accept) begin
                store_q    <= req_store;
                unsigned_q <= req_unsigned;
                size_q     <= req_size;
                lane_q     <= req_addr[1:0];
                wdata_q    <= req_wdata[15:0];
                err_q      <= misaligned;
                if (!misaligned) begin
                    addr_b_q <= {req_addr[31:2], 2'b00};
                    if (req_store && req_size == 2'b10) din_b_q <= req_wdata;
                end
            end
            if (state_q == S_RD_WAIT && bValid) begin
                rd_word_q <= doutB;
                if (store_q) din_b_q <= merged;
            end
            if (timeout) err_q <= 1'b1;
            if (state_q == S_RESP) begin
                rsp_err_q   <= err_q;
                rsp_rdata_q <= (err_q || store_q) ? 32'd0 : load_data;
            end
        end
    end

    assign memOp     = mem_op_q;
    assign addrB     = addr_b_q;
    assign dinB      = din_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a one-cycle-latency word memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  memOp;
    logic [31:0] addrB;
    logic [31:0] dinB;
    logic [31:0] doutB = 32'd0;
    logic        bvalid_raw = 1'b0;
    logic        tie_low = 1'b0;
    logic        bValid;
    logic        mem_ready = 1'b1;

    logic [31:0] mem [0:63];

    int checks = 0;
    int failures = 0;

    int          r_lat, r_nrd, r_nwr;
    logic [1:0]  r_rdop;
    logic [31:0] r_rdaddr, r_wrdin, r_wraddr, r_rdata;
    logic        r_err, r_ready_before, r_ready_at, r_pulse_after;

    always #5 clk = ~clk;

    assign bValid = bvalid_raw && !tie_low;

    mem_access_unit #(.TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .memOp(memOp), .addrB(addrB), .dinB(dinB),
        .doutB(doutB), .bValid(bValid), .mem_ready(mem_ready)
    );

    always @(posedge clk) begin
        bvalid_raw <= (memOp == 2'b01 || memOp == 2'b10);
        doutB      <= mem[addrB[7:2]];
        if (memOp == 2'b11) mem[addrB[7:2]] <= dinB;
    end

    // Issues one request at posedge+1 phase and records what the unit did until rsp_valid.
    task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] w);
        req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = w;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        r_lat = -1; r_nrd = 0; r_nwr = 0; r_rdop = 2'b00;
        r_rdaddr = 32'd0; r_wrdin = 32'd0; r_wraddr = 32'd0;
        r_rdata = 32'hx; r_err = 1'bx; r_ready_before = 1'bx; r_ready_at = 1'bx;
        for (int k = 0; k < 40; k++) begin
            if (memOp == 2'b01 || memOp == 2'b10) begin
                r_nrd++; r_rdop = memOp; r_rdaddr = addrB;
            end
            if (memOp == 2'b11) begin
                r_nwr++; r_wrdin = dinB; r_wraddr = addrB;
            end
            if (rsp_valid) begin
                r_lat = k; r_rdata = rsp_rdata; r_err = rsp_err; r_ready_at = req_ready;
                break;
            end
            r_ready_before = req_ready;
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
        r_pulse_after = rsp_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (memOp !== 2'b00) begin failures++; $display("FAIL reset_memop got=%b exp=00", memOp); end
        checks++; if (addrB !== 32'd0) begin failures++; $display("FAIL reset_addrb got=%h exp=0", addrB); end
        checks++; if (dinB !== 32'd0) begin failures++; $display("FAIL reset_dinb got=%h exp=0", dinB); end
        checks++; if ({rsp_valid, rsp_err} !== 2'b00) begin failures++; $display("FAIL reset_rsp got=%b exp=00", {rsp_valid, rsp_err}); end
        checks++; if (rsp_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rsp_rdata); end
        reset = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_word_load();
        mem[6'h10] = 32'hDEADBEEF;
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        checks++; if (r_lat !== 3) begin failures++; $display("FAIL lw_latency got=%0d exp=3", r_lat); end
        checks++; if (r_nrd !== 1 || r_rdop !== 2'b01) begin failures++; $display("FAIL lw_readop got=%0d/%b exp=1/01", r_nrd, r_rdop); end
        checks++; if (r_rdaddr !== 32'h40) begin failures++; $display("FAIL lw_addrb got=%h exp=00000040", r_rdaddr); end
        checks++; if (r_nwr !== 0) begin failures++; $display("FAIL lw_nowrite got=%0d exp=0", r_nwr); end
        checks++; if (r_rdata !== 32'hDEADBEEF || r_err !== 1'b0) begin failures++; $display("FAIL lw_data got=%h/%b exp=deadbeef/0", r_rdata, r_err); end
        checks++; if (r_pulse_after !== 1'b0) begin failures++; $display("FAIL lw_pulse got=%b exp=0", r_pulse_after); end
    endtask

    task automatic test_extension();
        logic [1:0]  sz [4]  = '{2'b00, 2'b00, 2'b01, 2'b01};
        logic        un [4]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] ad [4]  = '{32'h47, 32'h47, 32'h46, 32'h44};
        logic [31:0] ex [4]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F22};
        logic [1:0]  op [4]  = '{2'b01, 2'b10, 2'b01, 2'b10};
        mem[6'h11] = 32'h80F17F22;
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, sz[i], un[i], ad[i], 32'd0);
            checks++; if (r_rdata !== ex[i] || r_err !== 1'b0) begin failures++; $display("FAIL ext_data[%0d] got=%h/%b exp=%h/0", i, r_rdata, r_err, ex[i]); end
            checks++; if (r_lat !== 3 || r_rdop !== op[i]) begin failures++; $display("FAIL ext_timing[%0d] got=%0d/%b exp=3/%b", i, r_lat, r_rdop, op[i]); end
        end
    endtask

    task automatic test_timeout();
        tie_low = 1'b1;
        do_req(1'b0, 2'b10, 1'b0, 32'h40, 32'd0);
        tie_low = 1'b0;
        checks++; if (r_lat !== 17) begin failures++; $display("FAIL to_latency got=%0d exp=17", r_lat); end
        checks++; if (r_err !== 1'b1 || r_rdata !== 32'd0) begin failures++; $display("FAIL to_rsp got=%b/%h exp=1/0", r_err, r_rdata); end
        checks++; if (r_ready_before !== 1'b0 || r_ready_at !== 1'b1) begin failures++; $display("FAIL to_ready got=%b%b exp=01", r_ready_before, r_ready_at); end
    endtask

    task automatic test_subword_store();
        mem[6'h12] = 32'h11223344;
        do_req(1'b1, 2'b00, 1'b0, 32'h49, 32'h000000AB);
        checks++; if (r_lat !== 4) begin failures++; $display("FAIL sb_latency got=%0d exp=4", r_lat); end
        checks++; if (r_nrd !== 1 || r_rdop !== 2'b10 || r_nwr !== 1) begin failures++; $display("FAIL sb_ops got=%0d/%b/%0d exp=1/10/1", r_nrd, r_rdop, r_nwr); end
        checks++; if (r_wrdin !== 32'h1122AB44 || r_wraddr !== 32'h48) begin failures++; $display("FAIL sb_dinb got=%h@%h exp=1122ab44@48", r_wrdin, r_wraddr); end
        checks++; if (r_err !== 1'b0 || r_rdata !== 32'd0) begin failures++; $display("FAIL sb_rsp got=%b/%h exp=0/0", r_err, r_rdata); end
        do_req(1'b1, 2'b01, 1'b0, 32'h4A, 32'h0000BEEF);
        checks++; if (mem[6'h12] !== 32'hBEEFAB44) begin failures++; $display("FAIL sh_mem got=%h exp=beefab44", mem[6'h12]); end
        do_req(1'b1, 2'b10, 1'b0, 32'h4C, 32'hCAFEF00D);
        checks++; if (r_lat !== 2 || r_nrd !== 0 || r_nwr !== 1) begin failures++; $display("FAIL sw_ops got=%0d/%0d/%0d exp=2/0/1", r_lat, r_nrd, r_nwr); end
        checks++; if (mem[6'h13] !== 32'hCAFEF00D) begin failures++; $display("FAIL sw_mem got=%h exp=cafef00d", mem[6'h13]); end
    endtask

    task automatic test_misaligned();
        logic        st [3] = '{1'b0, 1'b1, 1'b0};
        logic [1:0]  sz [3] = '{2'b10, 2'b01, 2'b11};
        logic [31:0] ad [3] = '{32'h42, 32'h43, 32'h40};
        for (int i = 0; i < 3; i++) begin
            do_req(st[i], sz[i], 1'b0, ad[i], 32'h12345678);
            checks++; if (r_lat !== 1 || r_err !== 1'b1) begin failures++; $display("FAIL mis_rsp[%0d] got=%0d/%b exp=1/1", i, r_lat, r_err); end
            checks++; if (r_nrd !== 0 || r_nwr !== 0) begin failures++; $display("FAIL mis_noop[%0d] got=%0d/%0d exp=0/0", i, r_nrd, r_nwr); end
            checks++; if (r_rdata !== 32'd0) begin failures++; $display("FAIL mis_rdata[%0d] got=%h exp=0", i, r_rdata); end
        end
    endtask

    task automatic test_backpressure_reset();
        int bad = 0;
        mem_ready = 1'b0;
        req_store = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h40;
        req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (req_ready !== 1'b0 || memOp !== 2'b00) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_noaccept got=%0d bad cycles exp=0", bad); end
        mem_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++; if (memOp !== 2'b01) begin failures++; $display("FAIL bp_accept got=%b exp=01", memOp); end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (memOp !== 2'b00 || req_ready !== 1'b1) begin failures++; $display("FAIL rst_abort got=%b/%b exp=00/1", memOp, req_ready); end
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp_valid !== 1'b0 || memOp !== 2'b00) bad++;
            @(posedge clk); #1;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rst_noresp got=%0d bad cycles exp=0", bad); end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        test_reset();
        test_word_load();
        test_extension();
        test_timeout();
        test_subword_store();
        test_misaligned();
        test_backpressure_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
